tdp_stream_reader: RTL

- Read-side client for one port of the 32K x 16 true-dual-port scratchpad (dummy_tdp).
- Takes a burst command (base address, word count) and issues sequential reads on the port.
- Absorbs the RAM's fixed read latency and forwards words on a valid/ready stream to the downstream compute stage, honouring backpressure without losing data.
- The other TDP port remains free for a concurrent writer.

---
 rtl/npu_mem_pkg.sv | 15 +
 rtl/tdp_rd_fifo.sv | 60 ++++++
 rtl/tdp_rd_fifo_chk.sv | 13 +
 rtl/tdp_stream_reader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU scratchpad stream clients (reader now, writer later).
package npu_mem_pkg;

   localparam int TDP_ADDR_W = 15;
   localparam int TDP_DATA_W = 16;
   localparam int TDP_RD_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } rd_state_t;

endpackage

// File: rtl/tdp_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; data_o shows the head entry whenever empty_o is low.
module tdp_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             wr_s;
   logic             rd_s;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign rd_s    = pop_i && (count_q != '0);
   assign wr_s    = push_i && ((count_q != CNT_W'(DEPTH)) || rd_s);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_s) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (rd_s) rd_ptr_q <= ptr_next(rd_ptr_q);
         case ({wr_s, rd_s})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (wr_s) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/tdp_rd_fifo_chk.sv
// Property checker for tdp_rd_fifo: a push must never land on a full FIFO.
module tdp_rd_fifo_chk (
   input logic clk_i,
   input logic rst_i,
   input logic push_i,
   input logic pop_i,
   input logic full_i
);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && full_i && !pop_i));

endmodule

// File: rtl/tdp_stream_reader.sv
// Burst reader for one TDP scratchpad port: issues sequential reads under a credit limit
// and replays the returned words on a valid/ready stream through a skid FIFO.
module tdp_stream_reader
   import npu_mem_pkg::*;
#(
   parameter int ADDR_W     = TDP_ADDR_W,
   parameter int DATA_W     = TDP_DATA_W,
   parameter int LEN_W      = 16,
   parameter int RD_LAT     = TDP_RD_LAT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   // One extra stage: the address register sits in front of the RAM's own latency.
   localparam int PIPE_N = RD_LAT + 1;

   rd_state_t         state_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [ADDR_W-1:0] addr_ptr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued_q;
   logic [LEN_W-1:0]  words_out_q;
   logic [PIPE_N-1:0] vpipe_q;

   logic [CNT_W-1:0]  fifo_count_s;
   logic [DATA_W-1:0] fifo_head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   int                inflight_s;
   logic              credit_ok_s;
   logic              accept_s;
   logic              launch_issue_s;
   logic              run_issue_s;
   logic              issue_s;
   logic              hs_s;
   logic              last_s;

   // Reads currently travelling through the address/RAM pipeline.
   always_comb begin
      inflight_s = 0;
      for (int i = 0; i < PIPE_N; i++) begin
         inflight_s = inflight_s + (vpipe_q[i] ? 1 : 0);
      end
   end

   assign credit_ok_s    = (inflight_s + int'(fifo_count_s)) < FIFO_DEPTH;
   // A new burst may also be taken during the done cycle, when busy is already low.
   assign accept_s       = start && ((state_q == IDLE) || ((state_q == FIN) && done_q));
   assign launch_issue_s = accept_s && (len != '0);
   assign run_issue_s    = (state_q == ISSUE) && credit_ok_s && !fifo_full_s;
   assign issue_s        = launch_issue_s || run_issue_s;
   assign hs_s           = m_valid && m_ready;
   assign last_s         = ((words_out_q + LEN_W'(1)) == len_q);

   assign busy     = busy_q;
   assign done     = done_q;
   assign ram_we   = 1'b0;
   assign ram_din  = '0;
   assign ram_addr = ram_addr_q;
   assign m_valid  = !fifo_empty_s;
   assign m_data   = fifo_empty_s ? '0 : fifo_head_s;
   assign m_last   = m_valid && last_s;

   // Burst control FSM with address generation and word counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ram_addr_q  <= '0;
         addr_ptr_q  <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         words_out_q <= '0;
         vpipe_q     <= '0;
      end else begin
         vpipe_q <= {vpipe_q[PIPE_N-2:0], issue_s};
         done_q  <= 1'b0;
         if (hs_s) words_out_q <= words_out_q + LEN_W'(1);
         if (run_issue_s) begin
            ram_addr_q <= addr_ptr_q;
            addr_ptr_q <= addr_ptr_q + ADDR_W'(1);
            issued_q   <= issued_q + LEN_W'(1);
         end
         if (accept_s) begin
            len_q       <= len;
            words_out_q <= '0;
            busy_q      <= 1'b1;
            if (len == '0) begin
               issued_q <= '0;
               state_q  <= FIN;
            end else begin
               ram_addr_q <= base_addr;
               addr_ptr_q <= base_addr + ADDR_W'(1);
               issued_q   <= LEN_W'(1);
               state_q    <= (len == LEN_W'(1)) ? DRAIN : ISSUE;
            end
         end else begin
            case (state_q)
               IDLE: state_q <= IDLE;
               ISSUE: begin
                  if (run_issue_s && ((issued_q + LEN_W'(1)) == len_q)) state_q <= DRAIN;
               end
               DRAIN: begin
                  if (hs_s && last_s) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
               FIN: begin
                  // Empty bursts arrive here without a pulse yet.
                  if (!done_q) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                  end
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   tdp_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (vpipe_q[PIPE_N-1]),
      .data_i  (ram_dout),
      .pop_i   (hs_s),
      .data_o  (fifo_head_s),
      .count_o (fifo_count_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

endmodule
